// File: rtl/af_peak_track.sv
// af_peak_track: autofocus contrast-peak tracker.
// Sums per-pixel sharpness over each video frame, remembers the lens step
// that gave the best frame in the coarse sweep and then in the fine sweep,
// and pulses AF_DONE once when the fine sweep reports completion.
module af_peak_track #(
  parameter int SW = 12,
  parameter int AW = 28
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          VS,
  input  logic          SHARP_VALID,
  input  logic [SW-1:0] SHARP,
  input  logic [10:0]   STEP,
  input  logic          V_C,
  input  logic          VCM_END,
  output logic [9:0]    STEP_UP,
  output logic [10:0]   FINE_STEP,
  output logic [AW-1:0] PEAK_SUM,
  output logic          AF_DONE
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    EVAL  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          vs_q;
  logic          vc_q;
  logic          vs_edge;
  logic          vc_rise;
  logic          done_req;
  logic          open_frame;
  logic          eval_win;
  logic [AW-1:0] acc;
  logic [10:0]   cap_step;
  logic          cap_ph;
  logic          frame_ok;
  logic          fine_lock;

  // Accumulator add that sticks at all-ones instead of wrapping.
  function automatic logic [AW-1:0] sat_add(input logic [AW-1:0] a,
                                            input logic [SW-1:0] b);
    logic [AW:0] s;
    s = {1'b0, a} + {{(AW + 1 - SW){1'b0}}, b};
    return s[AW] ? {AW{1'b1}} : s[AW-1:0];
  endfunction

  // Coarse steps above the 10-bit feedback range clamp to its top value.
  function automatic logic [9:0] clamp_step(input logic [10:0] s);
    return (s > 11'h3FF) ? 10'h3FF : s[9:0];
  endfunction

  // Edge detects, completion request and the "this frame beats the peak" test.
  always_comb begin
    vs_edge    = VS & ~vs_q;
    vc_rise    = V_C & ~vc_q;
    done_req   = VCM_END & V_C;
    open_frame = ((state == IDLE) && vs_edge) || (state == EVAL);
    eval_win   = (state == EVAL) && frame_ok && (acc > PEAK_SUM);
  end

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; a completion request overrides frame sequencing.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (done_req) begin
          state_nx = DONE;
        end else if (vs_edge) begin
          state_nx = ACCUM;
        end else begin
          state_nx = IDLE;
        end
      end
      ACCUM: begin
        if (done_req) begin
          state_nx = DONE;
        end else if (vs_edge) begin
          state_nx = EVAL;
        end else begin
          state_nx = ACCUM;
        end
      end
      EVAL: begin
        if (done_req) begin
          state_nx = DONE;
        end else begin
          state_nx = ACCUM;
        end
      end
      DONE:    state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  // Frame accumulation, frame validity tracking and best-step outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      vs_q      <= 1'b0;
      vc_q      <= 1'b0;
      acc       <= {AW{1'b0}};
      cap_step  <= 11'd0;
      cap_ph    <= 1'b0;
      frame_ok  <= 1'b0;
      fine_lock <= 1'b0;
      STEP_UP   <= 10'd0;
      FINE_STEP <= 11'd0;
      PEAK_SUM  <= {AW{1'b0}};
      AF_DONE   <= 1'b0;
    end else if (state != DONE) begin
      vs_q    <= VS;
      vc_q    <= V_C;
      AF_DONE <= (state_nx == DONE);

      // Start of a new frame: fresh sum, remember which lens step/phase it belongs to.
      if (open_frame) begin
        acc      <= {AW{1'b0}};
        cap_step <= STEP;
        cap_ph   <= V_C;
        frame_ok <= 1'b1;
      end else if (state == ACCUM) begin
        if (SHARP_VALID) begin
          acc <= sat_add(acc, SHARP);
        end
        // Lens moved or sweep phase changed while the frame was exposing.
        if ((STEP != cap_step) || (V_C != cap_ph)) begin
          frame_ok <= 1'b0;
        end
      end

      // Entering the fine sweep restarts the peak search around the coarse best.
      if (vc_rise) begin
        PEAK_SUM  <= {AW{1'b0}};
        FINE_STEP <= {1'b0, STEP_UP};
        fine_lock <= 1'b1;
      end else if (eval_win) begin
        PEAK_SUM <= acc;
        if (cap_ph) begin
          FINE_STEP <= cap_step;
        end else if (!fine_lock) begin
          STEP_UP <= clamp_step(cap_step);
        end
      end
    end else begin
      AF_DONE <= 1'b0;
    end
  end

endmodule
